// File: rtl/ps2_key_select_pkg.sv
// Shared PS/2 constants: set-2 piano-row scancodes, prefix bytes, receiver states
// and the scancode-to-note lookup used by the decoder.
package ps2_key_select_pkg;

    localparam logic [7:0] PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PREFIX_EXT   = 8'hE0;

    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_E = 8'h24;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_F = 8'h2B;
    localparam logic [7:0] KEY_T = 8'h2C;
    localparam logic [7:0] KEY_G = 8'h34;
    localparam logic [7:0] KEY_Y = 8'h35;
    localparam logic [7:0] KEY_H = 8'h33;
    localparam logic [7:0] KEY_U = 8'h3C;
    localparam logic [7:0] KEY_J = 8'h3B;

    localparam int NUM_KEYS = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_hit_t;

    // Chromatic note index (C=0 .. B=11) for a make code, or hit=0 if unmapped.
    function automatic key_hit_t key_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 4'd0;
        case (code)
            KEY_A:   r.idx = 4'd0;
            KEY_W:   r.idx = 4'd1;
            KEY_S:   r.idx = 4'd2;
            KEY_E:   r.idx = 4'd3;
            KEY_D:   r.idx = 4'd4;
            KEY_F:   r.idx = 4'd5;
            KEY_T:   r.idx = 4'd6;
            KEY_G:   r.idx = 4'd7;
            KEY_Y:   r.idx = 4'd8;
            KEY_H:   r.idx = 4'd9;
            KEY_U:   r.idx = 4'd10;
            KEY_J:   r.idx = 4'd11;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_select_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, framing FSM
// with inter-edge timeout. Emits each good byte with a strobe, or an error pulse.
module ps2_key_select_rx
    import ps2_key_select_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_strobe,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_clk_reg;
    logic          flip;
    logic          fall;
    logic          data_bit;

    rx_state_t     state_reg;
    logic [2:0]    bitcnt_reg;
    logic [7:0]    sr_reg;
    logic          parity_reg;
    logic [TW-1:0] tcnt_reg;

    // Lines idle high, so synchronizers and filter reset to 1 to avoid a fake fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    assign data_bit = data_sync_reg[1];
    assign flip     = (clk_sync_reg[1] != filt_clk_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
    assign fall     = flip && filt_clk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (clk_sync_reg[1] == filt_clk_reg) begin
            filt_cnt_reg <= '0;
        end else if (flip) begin
            filt_clk_reg <= clk_sync_reg[1];
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            bitcnt_reg  <= '0;
            sr_reg      <= '0;
            parity_reg  <= 1'b0;
            tcnt_reg    <= '0;
            scan_code   <= '0;
            scan_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            scan_strobe <= 1'b0;
            frame_err   <= 1'b0;
            if (state_reg == ST_IDLE || fall) tcnt_reg <= '0;
            else                              tcnt_reg <= tcnt_reg + TW'(1);

            if (fall) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!data_bit) begin
                            state_reg  <= ST_DATA;
                            bitcnt_reg <= '0;
                        end
                    end
                    ST_DATA: begin
                        sr_reg     <= {data_bit, sr_reg[7:1]};
                        bitcnt_reg <= bitcnt_reg + 3'd1;
                        if (bitcnt_reg == 3'd7) state_reg <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_reg <= data_bit;
                        state_reg  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_bit && (^{sr_reg, parity_reg})) begin
                            scan_code   <= sr_reg;
                            scan_strobe <= 1'b1;
                        end else begin
                            frame_err   <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end else if (state_reg != ST_IDLE && tcnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_reg <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_select.sv
// PS/2 keyboard to 12-note held-key bitmap: receiver plus make/break decoder
// tracking F0 (break) and E0 (extended) prefixes.
module ps2_key_select
    import ps2_key_select_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] keySelect,
    output logic [7:0]  scan_code,
    output logic        scan_strobe,
    output logic        frame_err
);

    logic             brk_reg;
    logic             ext_reg;
    logic [11:0]      key_reg;
    logic             is_prefix;
    key_hit_t         hit;

    ps2_key_select_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .scan_strobe (scan_strobe),
        .frame_err   (frame_err)
    );

    assign hit       = key_lookup(scan_code);
    assign is_prefix = (scan_code == PREFIX_BREAK) || (scan_code == PREFIX_EXT);

    // Any non-prefix byte terminates the current prefix sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_reg <= 1'b0;
            ext_reg <= 1'b0;
        end else if (scan_strobe) begin
            if (scan_code == PREFIX_BREAK) begin
                brk_reg <= 1'b1;
            end else if (scan_code == PREFIX_EXT) begin
                ext_reg <= 1'b1;
            end else begin
                brk_reg <= 1'b0;
                ext_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                key_reg[gi] <= 1'b0;
            else if (scan_strobe && !is_prefix && !ext_reg && hit.hit && hit.idx == 4'(gi))
                key_reg[gi] <= ~brk_reg;
        end
    end

    assign keySelect = key_reg;

endmodule

// File: tb/tb_ps2_key_select.sv
// Bench for ps2_key_select: table of PS/2 frames with expected bitmaps, a scoreboard
// for strobe/error events, and hand sequences for timeout, glitches and async reset.
`timescale 1ns/1ps
module tb_ps2_key_select;

    localparam int TIMEOUT = 200;   // 200 cycles at a 1 MHz bench clock = 200 us

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] keySelect;
    logic [7:0]  scan_code;
    logic        scan_strobe;
    logic        frame_err;

    ps2_key_select #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keySelect   (keySelect),
        .scan_code   (scan_code),
        .scan_strobe (scan_strobe),
        .frame_err   (frame_err)
    );

    always #500 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        logic [7:0]  code;
        bit          bad_parity;
        logic [11:0] exp_key;
    } vec_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (scan_strobe || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=strobe%0b/err%0b/code%02h required=none",
                         scan_strobe, frame_err, scan_code);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_err", 32'(frame_err), 32'(e.is_err));
                check("event_kind_strobe", 32'(scan_strobe), 32'(!e.is_err));
                if (!e.is_err) check("scan_code", 32'(scan_code), 32'(e.code));
            end
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        #20000;
        ps2_clk = 1'b0;
        #40000;
        ps2_clk = 1'b1;
        #20000;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity);
        ev_t e;
        e.is_err = bad_parity;
        e.code   = b;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_parity ? (^b) : ~(^b));
        send_bit(1'b1);
        #20000;
    endtask

    task automatic frame_and_check(input string name, input logic [7:0] b, input bit bad,
                                   input logic [11:0] exp_key);
        send_frame(b, bad);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_key"}, 32'(keySelect), 32'(exp_key));
        $display("frame %02h bad_parity=%0b keySelect=%03h expected=%03h", b, bad, keySelect, exp_key);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{8'h1C, 1'b0, 12'h001},
            '{8'h3B, 1'b0, 12'h801},
            '{8'hF0, 1'b0, 12'h801},
            '{8'h1C, 1'b0, 12'h800},
            '{8'h24, 1'b1, 12'h800},
            '{8'hF0, 1'b0, 12'h800},
            '{8'h3B, 1'b0, 12'h000},
            '{8'hE0, 1'b0, 12'h000},
            '{8'h1C, 1'b0, 12'h000},
            '{8'hE0, 1'b0, 12'h000},
            '{8'hF0, 1'b0, 12'h000},
            '{8'h1C, 1'b0, 12'h000},
            '{8'h1C, 1'b0, 12'h001},
            '{8'h1C, 1'b0, 12'h001},
            '{8'hAA, 1'b0, 12'h001},
            '{8'hF0, 1'b0, 12'h001},
            '{8'h1C, 1'b0, 12'h000}
        };

        repeat (3) @(posedge clk);
        #100;
        check("rst_key", 32'(keySelect), 32'd0);
        check("rst_code", 32'(scan_code), 32'd0);
        check("rst_strobe", 32'(scan_strobe), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        #20000;

        foreach (vecs[i]) frame_and_check("vec", vecs[i].code, vecs[i].bad_parity, vecs[i].exp_key);

        // Truncated frame: start + 4 data bits, then silence.
        begin
            ev_t e;
            e.is_err = 1'b1;
            e.code   = 8'h00;
            exp_q.push_back(e);
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(i[0]);
            ps2_data = 1'b1;
            #120000;
            check("timeout_not_early", 32'(exp_q.size()), 32'd1);
            #180000;
            check("timeout_fired", 32'(exp_q.size()), 32'd0);
            check("timeout_key", 32'(keySelect), 32'h000);
            $display("timeout frame keySelect=%03h", keySelect);
        end
        frame_and_check("after_timeout", 8'h1D, 1'b0, 12'h002);

        // One-cycle ps2_clk glitches with data low must not start a frame.
        ps2_data = 1'b0;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk);
            #100;
            ps2_clk = 1'b0;
            @(posedge clk);
            #100;
            ps2_clk = 1'b1;
            #5000;
        end
        ps2_data = 1'b1;
        #300000;
        check("glitch_no_event", 32'(exp_q.size()), 32'd0);
        check("glitch_key", 32'(keySelect), 32'h002);
        $display("glitch burst keySelect=%03h", keySelect);
        frame_and_check("after_glitch", 8'h1C, 1'b0, 12'h003);

        frame_and_check("fill", 8'h1B, 1'b0, 12'h007);
        frame_and_check("fill", 8'h24, 1'b0, 12'h00F);
        frame_and_check("fill", 8'h23, 1'b0, 12'h01F);
        frame_and_check("fill", 8'h2B, 1'b0, 12'h03F);
        frame_and_check("fill", 8'h2C, 1'b0, 12'h07F);
        frame_and_check("fill", 8'h34, 1'b0, 12'h0FF);

        // Async reset in the middle of a frame, between clock edges.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        #20000;
        ps2_clk = 1'b0;
        @(posedge clk);
        #200;
        rst_n = 1'b0;
        #100;
        check("async_rst_key", 32'(keySelect), 32'd0);
        check("async_rst_code", 32'(scan_code), 32'd0);
        check("async_rst_strobe", 32'(scan_strobe), 32'd0);
        check("async_rst_err", 32'(frame_err), 32'd0);
        $display("async reset keySelect=%03h scan_code=%02h", keySelect, scan_code);
        ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
        #100;
        rst_n = 1'b1;
        #100000;
        check("post_rst_quiet", 32'(exp_q.size()), 32'd0);
        frame_and_check("post_rst", 8'h23, 1'b0, 12'h010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #80_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
